fetch_seq: RTL

- Instruction-fetch sequencer in front of the `pc` register and the instruction memory port.
- Drives `pc`'s jmp/rel/nxt controls to boot, advance, stall and redirect it.
- Runs a req/ack handshake with imem and buffers one fetched instruction for decode under a valid/ready handshake.
- Squashes wrong-path fetches on redirect and traps misaligned redirect targets.

---
 rtl/fetch_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_seq.sv
`default_nettype none
// ==========================================================================
// fetch_seq : instruction-fetch sequencer (pc control, imem req/ack, decode buffer)
// rev 1.0
// ==========================================================================
module fetch_seq #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_jmp,
  output logic        pc_rel,
  output logic [31:0] pc_nxt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redir_valid,
  input  logic        redir_rel,
  input  logic [31:0] redir_base,
  input  logic [31:0] redir_off,
  output logic        fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2
  } state_t;

  state_t      state;
  logic        pending;
  logic [31:0] kill_addr;

  logic [31:0] redir_tgt;
  logic        redir_mis;
  logic [31:0] load_tgt;
  logic        redir_take;
  logic        ack_take;

  assign redir_tgt  = redir_rel ? (redir_base + redir_off) : redir_off;
  assign redir_mis  = (redir_tgt[1:0] != 2'b00);
  assign load_tgt   = redir_mis ? TRAP_VEC : redir_tgt;
  assign redir_take = redir_valid && (state != BOOT);
  assign ack_take   = imem_req && imem_ack;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_cur;
    case (state)
      FETCH:   imem_req = pending | ~inst_valid | inst_ready;
      KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Default is HOLD (pc += 0); only ADV and absolute loads otherwise.
  always_comb begin
    pc_jmp = 1'b1;
    pc_rel = 1'b1;
    pc_nxt = 32'h0;
    if (state == BOOT) begin
      pc_rel = 1'b0;
      pc_nxt = RESET_VEC;
    end else if (redir_take) begin
      pc_rel = 1'b0;
      pc_nxt = load_tgt;
    end else if ((state == FETCH) && ack_take) begin
      pc_jmp = 1'b0;
      pc_rel = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pending    <= 1'b0;
      kill_addr  <= 32'h0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end else begin
      fault <= 1'b0;
      case (state)
        BOOT: state <= FETCH;
        FETCH, KILL: begin
          if (redir_take) begin
            inst_valid <= 1'b0;
            pending    <= 1'b0;
            if (redir_mis) begin
              fault      <= 1'b1;
              fault_addr <= redir_tgt;
            end
            // An unanswered request must still be retired before fetching the new path.
            if (imem_req && !imem_ack) begin
              state <= KILL;
              if (state == FETCH) kill_addr <= pc_cur;
            end else begin
              state <= FETCH;
            end
          end else if (state == KILL) begin
            if (imem_ack) state <= FETCH;
          end else if (ack_take) begin
            inst       <= imem_rdata;
            inst_pc    <= pc_cur;
            inst_valid <= 1'b1;
            pending    <= 1'b0;
          end else begin
            pending <= imem_req;
            if (inst_valid && inst_ready) inst_valid <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire
